// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a 3-digit common-anode seven-segment display.
//   Digit 1 shows in1, digit 2 shows in2 and digit 3 shows (in1+in2) mod 16,
//   all in hex. Each digit is lit for CLK_DIV cycles and is followed by
//   BLANK_CYCLES cycles with everything off, which suppresses ghosting.
//
// Ports
//   clk  in   1  system clock, rising edge
//   rst  in   1  asynchronous reset, active-low
//   en   in   1  display enable (0 blanks the outputs, scanning keeps running)
//   in1  in   4  operand A, asynchronous switch input, bit 0 = MSB
//   in2  in   4  operand B, asynchronous switch input, bit 0 = MSB
//   an   out  3  anode selects, active-low, an[1] = leftmost digit
//   seg  out  7  segments a..g (seg[1] = a), active-low
module seg7_scan_driver #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [0:3] in1,
  input  logic [0:3] in2,
  output logic [1:3] an,
  output logic [1:7] seg
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  // The counter only ever has to reach CNT_MAX-1.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-stage synchronizers, one per operand.
  // ---------------------------------------------------------------------------
  logic [3:0] raw [2];
  logic [3:0] sync_a_reg [2];
  logic [3:0] sync_b_reg [2];

  assign raw[0] = in1;
  assign raw[1] = in2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_a_reg[gi] <= 4'h0;
          sync_b_reg[gi] <= 4'h0;
        end else begin
          sync_a_reg[gi] <= raw[gi];
          sync_b_reg[gi] <= sync_a_reg[gi];
        end
      end
    end
  endgenerate

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] sum;

  assign s1  = sync_b_reg[0];
  assign s2  = sync_b_reg[1];
  assign sum = s1 + s2;  // carry intentionally dropped: 4-bit wrap

  // ---------------------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;   // 1..3
  logic [3:0]       val_reg, val_next;
  logic [3:0]       digit_sel;
  logic [2:0]       an_next;
  logic [6:0]       seg_next;
  logic [2:0]       an_reg;
  logic [6:0]       seg_reg;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'b0000001;
      4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;
      4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;
      4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;
      4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;
      4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;
      default: r = 7'b0111000;
    endcase
    return r;
  endfunction

  always_comb begin
    digit_sel = sum;
    case (idx_reg)
      2'd1:    digit_sel = s1;
      2'd2:    digit_sel = s2;
      default: digit_sel = sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= BLANK;
      cnt_reg   <= '0;
      idx_reg   <= 2'd1;
      val_reg   <= 4'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      val_reg   <= val_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    val_next   = val_reg;
    case (state_reg)
      BLANK: begin
        if (cnt_reg == CNT_W'(BLANK_CYCLES - 1)) begin
          state_next = SHOW;
          cnt_next   = '0;
          val_next   = digit_sel;  // held for the whole SHOW period
        end
      end
      default: begin
        if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = (idx_reg == 2'd3) ? 2'd1 : idx_reg + 2'd1;
        end
      end
    endcase
  end

  // Outputs are computed from the upcoming state so the registered pins line
  // up exactly with the state they represent.
  always_comb begin
    an_next  = 3'b111;
    seg_next = 7'b1111111;
    if (state_next == SHOW) begin
      seg_next = decode(val_next);
      case (idx_next)
        2'd1:    an_next = 3'b011;
        2'd2:    an_next = 3'b101;
        2'd3:    an_next = 3'b110;
        default: an_next = 3'b111;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_reg  <= 3'b111;
      seg_reg <= 7'b1111111;
    end else if (!en) begin
      an_reg  <= 3'b111;
      seg_reg <= 7'b1111111;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver with CLK_DIV=8, BLANK_CYCLES=2.
//   A schedule model (frame position from an edge count) predicts an/seg on
//   every cycle; literal checks pin the model at key points.
module tb_seg7_scan_driver;

  localparam int D     = 8;
  localparam int B     = 2;
  localparam int SLOT  = D + B;
  localparam int FRAME = 3 * SLOT;
  localparam int HMAX  = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic [0:3] in1 = 4'h0;
  logic [0:3] in2 = 4'h0;
  logic [1:3] an;
  logic [1:7] seg;

  seg7_scan_driver #(.CLK_DIV(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .en(en), .in1(in1), .in2(in2), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [6:0] dec [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // ---------------------------------------------------------------------------
  // Reference model: n = rising edges since reset release. Position in the
  // frame decides blank/lit and which digit; the digit value is the operand
  // sampled two edges before the lighting edge.
  // ---------------------------------------------------------------------------
  int         n = 0;
  logic [3:0] h1 [HMAX];
  logic [3:0] h2 [HMAX];
  logic [3:0] mval = 4'h0;
  logic [9:0] exp_out = 10'h3FF;
  bit         chk_on = 1'b0;
  int         p, slot, o;
  logic [3:0] ma, mb;
  logic [2:0] man;

  always @(posedge clk) begin
    if (!rst) begin
      n       = 0;
      mval    = 4'h0;
      exp_out = 10'h3FF;
    end else begin
      n = n + 1;
      h1[n % HMAX] = in1;
      h2[n % HMAX] = in2;
      p    = n % FRAME;
      slot = p / SLOT;
      o    = p % SLOT;
      if (o == B) begin
        ma = (n - 2 >= 1) ? h1[(n - 2) % HMAX] : 4'h0;
        mb = (n - 2 >= 1) ? h2[(n - 2) % HMAX] : 4'h0;
        if (slot == 0)      mval = ma;
        else if (slot == 1) mval = mb;
        else                mval = 4'(ma + mb);
      end
      man = (slot == 0) ? 3'b011 : (slot == 1) ? 3'b101 : 3'b110;
      if (!en || o < B) exp_out = 10'h3FF;
      else              exp_out = {man, dec[mval]};
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({an, seg} !== exp_out) begin
        failures++;
        $display("FAIL model n=%0d an=%b seg=%b expected an=%b seg=%b",
                 n, an, seg, exp_out[9:7], exp_out[6:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s n=%0d got=%b want=%b", name, n, act, want);
    end else begin
      $display("ok   %s n=%0d value=%b", name, n, act);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Advance at least one cycle, then until the frame position equals ph.
  task automatic wait_phase(input int ph);
    int cnt;
    cnt = 0;
    step(1);
    while ((n % FRAME) != ph && cnt < 2 * FRAME) begin
      step(1);
      cnt++;
    end
    checks++;
    if ((n % FRAME) != ph) begin
      failures++;
      $display("FAIL wait_phase got=%0d want=%0d", n % FRAME, ph);
    end
  endtask

  initial begin
    // Power-up reset, then release with in1=3, in2=5.
    rst = 1'b0; in1 = 4'h3; in2 = 4'h5; en = 1'b1;
    step(3);
    chk("reset_out", {an, seg}, 10'h3FF);
    rst = 1'b1;
    chk_on = 1'b1;
    step(1);  chk("cyc1_blank", {7'b0, an}, {7'b0, 3'b111});
    step(1);  chk("cyc2_digit1_an", {7'b0, an}, {7'b0, 3'b011});
    step(9);  chk("cyc11_blank", {an, seg}, 10'h3FF);
    step(1);  chk("cyc12_digit2_5", {an, seg}, {3'b101, 7'b0100100});
    step(10); chk("cyc22_digit3_8", {an, seg}, {3'b110, 7'b0000000});
    step(10); chk("cyc32_digit1_3", {an, seg}, {3'b011, 7'b0000110});

    // Sum wraps modulo 16.
    in1 = 4'h9; in2 = 4'h8;
    step(20); chk("sum_9p8_is_1", {an, seg}, {3'b110, 7'b1001111});
    in1 = 4'hF; in2 = 4'hF;
    step(30); chk("sum_FpF_is_E", {an, seg}, {3'b110, 7'b0110000});

    // Digit-1 sweep over all hex values.
    for (int v = 0; v < 16; v++) begin
      in1 = 4'(v);
      wait_phase(2);
      wait_phase(2);
      chk($sformatf("sweep_%0h", v), {an, seg}, {3'b011, dec[v]});
    end

    // Mid-SHOW input change must not disturb the digit being shown.
    in1 = 4'h2;
    wait_phase(2);
    wait_phase(2);
    chk("hold_start_2", {an, seg}, {3'b011, 7'b0010010});
    step(3); in1 = 4'h7;
    step(4); chk("hold_end_2", {an, seg}, {3'b011, 7'b0010010});
    step(1); chk("hold_blank", {an, seg}, 10'h3FF);
    wait_phase(2);
    chk("next_frame_7", {an, seg}, {3'b011, 7'b0001111});

    // Enable off for 20 clocks mid-frame.
    wait_phase(15);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("en_off", {an, seg}, 10'h3FF);
    end
    en = 1'b1;
    step(1);
    chk("en_resume", {an, seg}, {3'b011, 7'b0001111});

    // Randomized operands and enable.
    for (int i = 0; i < 600; i++) begin
      step(1);
      if ($urandom_range(7) == 0) in1 = 4'($urandom_range(15));
      if ($urandom_range(7) == 0) in2 = 4'($urandom_range(15));
      en = ($urandom_range(15) != 0);
    end
    en = 1'b1;

    // Reset in the middle of digit 2's SHOW.
    in1 = 4'h4; in2 = 4'h6;
    wait_phase(15);
    #2 rst = 1'b0;
    #1 chk("async_reset", {an, seg}, 10'h3FF);
    step(2);
    rst = 1'b1;
    step(1);  chk("restart_cyc1", {7'b0, an}, {7'b0, 3'b111});
    step(1);  chk("restart_cyc2", {7'b0, an}, {7'b0, 3'b011});
    step(10); chk("restart_digit2_6", {an, seg}, {3'b101, 7'b0100000});
    step(5);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
